// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// registers the returned word into IF/ID with PC+4, a valid bit and a saturating fetch count.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Freeze,
   input  logic             BranchTaken,
   input  logic [31:0]      BranchAddr,
   output logic [31:0]      InstAddr,
   input  logic [31:0]      InstIn,
   output logic [31:0]      PcOut,
   output logic [31:0]      InstOut,
   output logic             ValidOut,
   output logic [CNT_W-1:0] FetchCount
);

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

   logic [31:0] pc;
   logic [31:0] pc_inc;

   // PC only ever takes aligned values, so PC+4 wraps 0xFFFF_FFFC -> 0 and stays aligned.
   assign pc_inc   = pc + 32'd4;
   assign InstAddr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC_ALIGNED;
         PcOut      <= '0;
         InstOut    <= '0;
         ValidOut   <= 1'b0;
         FetchCount <= '0;
      end else if (BranchTaken) begin
         // Redirect overrides a concurrent freeze; the wrong-path word becomes a bubble.
         pc       <= BranchAddr & ~32'h3;
         PcOut    <= '0;
         InstOut  <= '0;
         ValidOut <= 1'b0;
      end else if (!Freeze) begin
         pc       <= pc_inc;
         PcOut    <= pc_inc;
         InstOut  <= InstIn;
         ValidOut <= 1'b1;
         if (FetchCount != '1)
            FetchCount <= FetchCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a reference model pushes expected IF/ID state per
// cycle, which is popped and compared after each clock edge.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] inst_addr, inst_in, pc_out, inst_out;
   logic        valid_out;
   logic [15:0] fetch_count;
   logic [31:0] inst_addr4, inst_in4, pc_out4, inst_out4;
   logic        valid_out4;
   logic [3:0]  fetch_count4;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pcout;
      logic [31:0] inst;
      logic        valid;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [15:0] idx);
      return 32'hE1A0_3000 ^ ({16'h0, idx} * 32'h0101_0101) ^ 32'h0000_0007;
   endfunction

   assign inst_in  = memword(inst_addr[17:2]);
   assign inst_in4 = memword(inst_addr4[17:2]);

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .Freeze(freeze), .BranchTaken(branch_taken),
      .BranchAddr(branch_addr), .InstAddr(inst_addr), .InstIn(inst_in),
      .PcOut(pc_out), .InstOut(inst_out), .ValidOut(valid_out), .FetchCount(fetch_count)
   );

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .Freeze(freeze), .BranchTaken(branch_taken),
      .BranchAddr(branch_addr), .InstAddr(inst_addr4), .InstIn(inst_in4),
      .PcOut(pc_out4), .InstOut(inst_out4), .ValidOut(valid_out4), .FetchCount(fetch_count4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, push the model's post-edge state, then pop and compare.
   task automatic step(input logic r, input logic fz, input logic br, input logic [31:0] ba);
      exp_t e;
      @(negedge clk);
      rst = r; freeze = fz; branch_taken = br; branch_addr = ba;
      if (r) begin
         m.pc = 32'h0; m.pcout = '0; m.inst = '0; m.valid = 1'b0; m.cnt = '0; m.cnt4 = '0;
      end else if (br) begin
         m.pc = {ba[31:2], 2'b00}; m.pcout = '0; m.inst = '0; m.valid = 1'b0;
      end else if (!fz) begin
         m.inst  = memword(m.pc[17:2]);
         m.pc    = m.pc + 32'd4;
         m.pcout = m.pc;
         m.valid = 1'b1;
         if (m.cnt  != 16'hFFFF) m.cnt  = m.cnt + 16'd1;
         if (m.cnt4 != 4'hF)     m.cnt4 = m.cnt4 + 4'd1;
      end
      exp_q.push_back(m);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("inst_addr",   inst_addr,          e.pc);
      check("pc_out",      pc_out,             e.pcout);
      check("inst_out",    inst_out,           e.inst);
      check("valid_out",   32'(valid_out),     32'(e.valid));
      check("fetch_count", 32'(fetch_count),   32'(e.cnt));
      check("fetch_cnt4",  32'(fetch_count4),  32'(e.cnt4));
      check("inst_addr4",  inst_addr4,         e.pc);
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      m = '{pc: '0, pcout: '0, inst: '0, valid: 1'b0, cnt: '0, cnt4: '0};

      // Reset, then four free-running fetches from word 0.
      for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_addr",  inst_addr,      32'h0);
      run(4);
      check("t1_addr",  inst_addr,        32'd16);
      check("t1_pcout", pc_out,           32'd16);
      check("t1_inst",  inst_out,         memword(16'd3));
      check("t1_cnt",   32'(fetch_count), 32'd4);

      // Freeze at PC=8 for three cycles, then resume.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      run(2);
      for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      check("t2_addr",  inst_addr,        32'd8);
      check("t2_pcout", pc_out,           32'd8);
      check("t2_inst",  inst_out,         memword(16'd1));
      check("t2_cnt",   32'(fetch_count), 32'd2);
      run(3);

      // Branch at PC=20 to 0x60.
      step(1'b0, 1'b0, 1'b1, 32'h60);
      check("t3_addr",  inst_addr,       32'h60);
      check("t3_valid", 32'(valid_out),  32'd0);
      run(1);
      check("t3_inst",  inst_out,        memword(16'd24));
      check("t3_pcout", pc_out,          32'h64);

      // Branch overrides freeze; unaligned target is truncated.
      step(1'b0, 1'b1, 1'b1, 32'h47);
      check("t4_addr",  inst_addr,       32'h44);
      check("t4_valid", 32'(valid_out),  32'd0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      run(1);

      // Reset while frozen at PC=0x30.
      step(1'b0, 1'b0, 1'b1, 32'h30);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("t5_addr", inst_addr,        32'h0);
      check("t5_cnt",  32'(fetch_count), 32'd0);
      run(2);

      // PC wrap and saturation of the narrow counter.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      run(1);
      check("t6_addr",  inst_addr, 32'h0);
      check("t6_pcout", pc_out,    32'h0);
      run(20);
      check("t6_sat4",  32'(fetch_count4), 32'd15);
      check("t6_cnt16", 32'(fetch_count),  32'd23);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
